// File: rtl/clock_divider_bank.sv
// -----------------------------------------------------------------------------
// clock_divider_bank
//
// Programmable multi-channel clock divider. Each channel produces a 50% duty
// divided clock (period = 2*half system cycles) plus a one-cycle tick on each
// rising edge of that clock. Half-periods are reprogrammed through a one-deep
// pending slot per channel. A pending value is only applied at a clean point:
// the falling edge of the divided clock, any edge while the channel is
// disabled, or a resync. Because of this, a reprogram never produces a short
// pulse.
//
// Ports
//   clock_i      system clock, rising-edge active
//   reset_i      synchronous active-high reset
//   resync_i     single-cycle request to phase-align all channels
//   cfg_valid_i  configuration write request
//   cfg_ch_i     target channel of the write
//   cfg_half_i   new half-period in system cycles (0 disables the channel)
//   cfg_ready_o  write to cfg_ch_i can be accepted this cycle (combinational)
//   clk_out_o    divided clocks, one bit per channel (registered)
//   tick_o       one-cycle pulse on each rising edge of clk_out_o (registered)
//   active_o     channel half-period is non-zero (registered)
// -----------------------------------------------------------------------------
module clock_divider_bank #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              resync_i,
    input  logic              cfg_valid_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_half_i,
    output logic              cfg_ready_o,
    output logic [NUM_CH-1:0] clk_out_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] active_o
);

    logic [DIV_W-1:0]  half_q     [NUM_CH];
    logic [DIV_W-1:0]  half_d     [NUM_CH];
    logic [DIV_W-1:0]  cnt_q      [NUM_CH];
    logic [DIV_W-1:0]  cnt_d      [NUM_CH];
    logic [DIV_W-1:0]  pend_val_q [NUM_CH];
    logic [DIV_W-1:0]  pend_val_d [NUM_CH];
    logic [NUM_CH-1:0] out_q;
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] active_q;
    logic [NUM_CH-1:0] active_d;
    logic              ch_in_range_s;
    logic              cfg_accept_s;

    // Handshake: a channel can take a write only while its pending slot is empty.
    always_comb begin
        ch_in_range_s = (32'(cfg_ch_i) < NUM_CH);
        cfg_ready_o   = 1'b0;
        if (ch_in_range_s) begin
            cfg_ready_o = ~pend_q[cfg_ch_i];
        end else begin
            cfg_ready_o = 1'b0;
        end
        cfg_accept_s = cfg_valid_i & cfg_ready_o;
    end

    // Per-channel next state: resync, then disabled/apply, then normal counting.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            half_d[i]     = half_q[i];
            cnt_d[i]      = cnt_q[i];
            out_d[i]      = out_q[i];
            tick_d[i]     = 1'b0;
            pend_d[i]     = pend_q[i];
            pend_val_d[i] = pend_val_q[i];

            if (resync_i) begin
                cnt_d[i] = {DIV_W{1'b0}};
                out_d[i] = 1'b0;
                if (pend_q[i]) begin
                    half_d[i] = pend_val_q[i];
                    pend_d[i] = 1'b0;
                end else begin
                    half_d[i] = half_q[i];
                end
            end else if (half_q[i] == {DIV_W{1'b0}}) begin
                // Disabled: outputs held low; any pending value loads right away.
                cnt_d[i] = {DIV_W{1'b0}};
                out_d[i] = 1'b0;
                if (pend_q[i]) begin
                    half_d[i] = pend_val_q[i];
                    pend_d[i] = 1'b0;
                end else begin
                    half_d[i] = half_q[i];
                end
            end else if (cnt_q[i] == (half_q[i] - DIV_W'(1))) begin
                cnt_d[i]  = {DIV_W{1'b0}};
                out_d[i]  = ~out_q[i];
                tick_d[i] = ~out_q[i];
                // Only the 1->0 transition is a safe point to change the period.
                if (out_q[i] && pend_q[i]) begin
                    half_d[i] = pend_val_q[i];
                    pend_d[i] = 1'b0;
                end else begin
                    half_d[i] = half_q[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end

            // Accept overwrites pend_d only when pend_q was clear, so a write
            // landing on an apply edge stays pending for the next event.
            if (cfg_accept_s && (cfg_ch_i == CH_W'(i))) begin
                pend_d[i]     = 1'b1;
                pend_val_d[i] = cfg_half_i;
            end else begin
                pend_val_d[i] = pend_val_d[i];
            end

            active_d[i] = (half_d[i] != {DIV_W{1'b0}});
        end
    end

    // State registers with synchronous reset to the fixed /2^(i+1) defaults.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                half_q[i]     <= DIV_W'(1) << i;
                cnt_q[i]      <= {DIV_W{1'b0}};
                pend_val_q[i] <= {DIV_W{1'b0}};
            end
            out_q    <= {NUM_CH{1'b0}};
            tick_q   <= {NUM_CH{1'b0}};
            pend_q   <= {NUM_CH{1'b0}};
            active_q <= {NUM_CH{1'b1}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                half_q[i]     <= half_d[i];
                cnt_q[i]      <= cnt_d[i];
                pend_val_q[i] <= pend_val_d[i];
            end
            out_q    <= out_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
            active_q <= active_d;
        end
    end

    assign clk_out_o = out_q;
    assign tick_o    = tick_q;
    assign active_o  = active_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// -----------------------------------------------------------------------------
// Bench for clock_divider_bank (NUM_CH=4, DIV_W=8).
// A reference model written in terms of "edges since alignment" predicts the
// registered outputs. Those predictions go through a scoreboard queue, and
// directed checks pin the documented edge timings.
// -----------------------------------------------------------------------------
module tb_clock_divider_bank;

    localparam int NUM_CH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              resync;
    logic              cfg_valid;
    logic [1:0]        cfg_ch;
    logic [7:0]        cfg_half;
    logic              cfg_ready;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] active;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] exp_q[$];

    // reference model state
    int m_half [NUM_CH];
    int m_n    [NUM_CH];
    int m_pval [NUM_CH];
    bit m_pend [NUM_CH];
    bit rdy_known = 1'b0;
    int edge_n = 0;

    clock_divider_bank #(.NUM_CH(NUM_CH), .DIV_W(8)) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .resync_i    (resync),
        .cfg_valid_i (cfg_valid),
        .cfg_ch_i    (cfg_ch),
        .cfg_half_i  (cfg_half),
        .cfg_ready_o (cfg_ready),
        .clk_out_o   (clk_out),
        .tick_o      (tick),
        .active_o    (active)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_outputs();
        logic [3:0] c, t, a;
        c = 4'b0000; t = 4'b0000; a = 4'b0000;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_half[i] != 0) begin
                a[i] = 1'b1;
                c[i] = ((m_n[i] / m_half[i]) % 2) == 1;
                t[i] = c[i] && ((m_n[i] % m_half[i]) == 0);
            end
        end
        return {a, t, c};
    endfunction

    task automatic model_edge(input bit rst, input bit rs, input bit v, input int ch, input int hv);
        bit acc;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_half[i] = 1 << i; m_n[i] = 0; m_pend[i] = 1'b0; m_pval[i] = 0;
            end
        end else begin
            acc = v && !m_pend[ch];
            for (int i = 0; i < NUM_CH; i++) begin
                bit apply;
                apply = 1'b0;
                if (rs || m_half[i] == 0) begin
                    m_n[i] = 0;
                    apply  = m_pend[i];
                end else begin
                    m_n[i] = (m_n[i] + 1) % (2 * m_half[i]);
                    apply  = (m_n[i] == 0) && m_pend[i];
                end
                if (apply) begin
                    m_half[i] = m_pval[i]; m_pend[i] = 1'b0; m_n[i] = 0;
                end
            end
            if (acc) begin
                m_pend[ch] = 1'b1; m_pval[ch] = hv;
            end
        end
    endtask

    // Drive one cycle from a negedge, predict, wait an edge, compare at negedge.
    task automatic cycle(input bit rst, input bit rs, input bit v, input int ch, input int hv);
        logic [11:0] e;
        reset = rst; resync = rs; cfg_valid = v; cfg_ch = ch[1:0]; cfg_half = hv[7:0];
        #1;
        if (rdy_known) check_val("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend[ch]});
        model_edge(rst, rs, v, ch, hv);
        exp_q.push_back(model_outputs());
        if (rst || rs) edge_n = 0; else edge_n++;
        @(posedge clock);
        @(negedge clock);
        rdy_known = 1'b1;
        check_val("sb_depth", exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("clk_out", {28'd0, clk_out}, {28'd0, e[3:0]});
            check_val("tick",    {28'd0, tick},    {28'd0, e[7:4]});
            check_val("active",  {28'd0, active},  {28'd0, e[11:8]});
        end
    endtask

    task automatic idle(input int n, input int ch);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, ch, 0);
    endtask

    // Cycles between two consecutive ticks on a channel, bounded to 40 cycles.
    task automatic measure_period(input int ch, input int exp_p, input string tag);
        int first; bit found;
        first = -1; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle(1'b0, 1'b0, 1'b0, ch, 0);
            if (tick[ch] === 1'b1) begin
                if (first < 0) first = k;
                else begin
                    check_val(tag, k - first, exp_p);
                    found = 1'b1;
                end
            end
        end
        check_val({tag, "_seen"}, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; resync = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_half = 8'd0;
        @(negedge clock);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        check_val("rst_clk_out", {28'd0, clk_out}, 32'd0);
        check_val("rst_active", {28'd0, active}, 32'hF);

        // Reset defaults: ch2 rises after edge 4, falls after edge 8.
        for (int k = 0; k < 18; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1, 0);
            if (edge_n == 3) check_val("ch2_pre_rise", {31'd0, clk_out[2]}, 32'd0);
            if (edge_n == 4) begin
                check_val("ch2_rise", {31'd0, clk_out[2]}, 32'd1);
                check_val("tick2_hi", {31'd0, tick[2]}, 32'd1);
            end
            if (edge_n == 5) check_val("tick2_lo", {31'd0, tick[2]}, 32'd0);
            if (edge_n == 8) check_val("ch2_fall", {31'd0, clk_out[2]}, 32'd0);
            if (edge_n == 8) check_val("ch3_rise", {31'd0, clk_out[3]}, 32'd1);
        end

        // Reprogram ch1 while its clock is high; a second write is dropped.
        begin
            int k;
            k = 0;
            while (!(m_half[1] != 0 && ((m_n[1] / m_half[1]) % 2) == 1) && k < 20) begin
                cycle(1'b0, 1'b0, 1'b0, 1, 0);
                k++;
            end
            check_val("ch1_high_found", {31'd0, k < 20}, 32'd1);
        end
        cycle(1'b0, 1'b0, 1'b1, 1, 3);
        cycle(1'b0, 1'b0, 1'b1, 1, 7);
        cycle(1'b0, 1'b0, 1'b1, 3, 9);
        idle(6, 1);
        measure_period(1, 6, "ch1_period6");

        // Disable ch0, then re-enable with half 5.
        cycle(1'b0, 1'b0, 1'b1, 0, 0);
        idle(4, 0);
        check_val("ch0_off", {30'd0, active[0], clk_out[0]}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 0, 5);
        cycle(1'b0, 1'b0, 1'b0, 0, 0);
        check_val("ch0_reenabled", {31'd0, active[0]}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 0, 0);
            check_val("ch0_rise5", {31'd0, clk_out[0]}, {31'd0, k == 5});
        end
        measure_period(0, 10, "ch0_period10");

        // Mixed writes, then resync with a write pending on ch2.
        cycle(1'b0, 1'b0, 1'b1, 3, 2);
        cycle(1'b0, 1'b0, 1'b1, 1, 1);
        idle(7, 2);
        cycle(1'b0, 1'b0, 1'b1, 2, 6);
        cycle(1'b0, 1'b1, 1'b1, 3, 4);
        check_val("resync_clk", {28'd0, clk_out}, 32'd0);
        check_val("resync_tick", {28'd0, tick}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 2, 0);
            check_val("ch2_rise6", {31'd0, clk_out[2]}, {31'd0, k == 6});
            check_val("ch0_rise5b", {31'd0, clk_out[0]}, {31'd0, k >= 5});
        end
        idle(20, 3);

        // Reset mid-operation with pending writes.
        cycle(1'b0, 1'b0, 1'b1, 0, 2);
        cycle(1'b0, 1'b0, 1'b1, 2, 3);
        cycle(1'b1, 1'b0, 1'b0, 2, 0);
        check_val("mid_rst_clk", {28'd0, clk_out}, 32'd0);
        check_val("mid_rst_active", {28'd0, active}, 32'hF);
        measure_period(3, 16, "ch3_default16");
        measure_period(2, 8, "ch2_default8");

        // Random traffic with occasional resync.
        for (int k = 0; k < 300; k++) begin
            cycle(1'b0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Programmable multi-channel clock-divider bank. Generates NUM_CH divided clock outputs and matching rising-edge tick pulses from the single system clock. Replaces the fixed divide-by-2/divide-by-4 chain that feeds the processor and regfile clocks. Each channel's half-period can be reprogrammed at run time without glitches. A resync input phase-aligns all channels.

## Interface
- NUM_CH, default 4: number of divided-clock channels, 1..16.
- DIV_W, default 8: width of each half-period field; must be ≥ NUM_CH.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- resync  in  1  single-cycle request to phase-align all channels.
- cfg_valid  in  1  configuration write request.
- cfg_ch  in  ceil(log2(NUM_CH)), min 1  target channel of the write.
- cfg_half  in  DIV_W  new half-period in system-clock cycles; 0 disables the channel.
- cfg_ready  out  1  write can be accepted this cycle.
- clk_out  out  NUM_CH  divided clocks, one bit per channel, registered.
- tick  out  NUM_CH  one-cycle pulse on each rising edge of clk_out, registered.
- active  out  NUM_CH  bit i is 1 when channel i's current half-period is non-zero.

## Operation
- Per-channel state:
  - half[i] (DIV_W): current half-period.
  - cnt[i] (DIV_W): counter.
  - out[i]: divided clock.
  - pend[i] and pend_val[i]: one-deep pending-update slot.
- Reset applies to every channel: half[i] = 2^i (ch0 /2, ch1 /4, ch2 /8, ch3 /16), cnt = 0, out = 0, tick = 0, pend = 0.
- Normal count, when half[i] ≠ 0:
  - if cnt == half−1: cnt ← 0 and out toggles.
  - otherwise cnt increments.
  - Period is 2·half cycles at a 50% duty cycle.
- tick[i] is 1 exactly during the first cycle in which clk_out[i] is 1.
- Disabled channel (half == 0): out, cnt and tick are held at 0.
- Configuration handshake:
  - cfg_ready = ~pend[cfg_ch], combinational from cfg_ch.
  - A write is accepted when cfg_valid & cfg_ready; it sets pend = 1 and pend_val = cfg_half.
  - An out-of-range cfg_ch drives cfg_ready = 0 and the write is ignored.
- Update application is glitch-free. A pending value is loaded into half (with cnt ← 0, pend ← 0) only on one of these events, after the cycle of acceptance:
  - (a) the edge where out toggles 1→0;
  - (b) any edge while the channel is disabled;
  - (c) a resync edge.
- A write accepted on the same edge as one of these events is not applied until the next event.
- resync: every channel gets cnt ← 0, out ← 0, tick ← 0, and any pending value is applied.
- Priority on any edge: reset > resync > configuration apply/accept > count.
- A simultaneous cfg accept on the resync edge is stored as pending; it is not applied on that edge.
- Reset mid-operation discards pending writes and restores the reset half-periods.

## Timing
- All outputs except cfg_ready are registered; cfg_ready is the only combinational path (cfg_ch → cfg_ready).
- Output timing after reset or resync, counting edge 1 as the first edge with reset and resync low:
  - clk_out[i] rises after edge half[i];
  - it falls after edge 2·half[i];
  - this repeats.
- tick latency: tick rises on the same edge as clk_out; width is exactly 1 cycle, including half = 1.
- Write-to-effect latency is bounded by 2·half_old + 1 cycles for an enabled channel.
- A disabled channel takes the new value on the edge after acceptance. Its first rise is half_new edges after that.
- Throughput: one write per channel per apply event; writes to different channels are independent and may be issued back-to-back.
- Maximum half = 2^DIV_W − 1. No wrap: cnt never exceeds half − 1.

## Test plan
- Reset defaults, NUM_CH=4, DIV_W=8 → clk_out periods of 2/4/8/16 cycles. ch2 rises after edge 4 and falls after edge 8. tick[2] is high only for cycle 4→5. active = 4'b1111.
- Write ch1 cfg_half=3 while clk_out[1] is high → old /4 runs until its falling edge, then period becomes 6 with no short pulse. cfg_ready for ch1 is low until that edge.
- Second write to ch1 while pend[1]=1 → cfg_ready=0 and the write is dropped. A write to ch3 in the same window is accepted.
- Write ch0 cfg_half=0 → active[0] falls after the next ch0 falling edge and clk_out[0] stays 0. Then write cfg_half=5 → applied on the next edge, and clk_out[0] rises 5 edges later.
- Let channels drift after mixed writes, pulse resync with a pending write on ch2 → all clk_out low on the next edge and ch2 uses the new value. Each channel then rises after exactly half[i] edges.
- Assert reset for 1 cycle mid-operation with pending writes → all outputs 0, pending cleared, reset-default periods resume.
